// File: rtl/rr_arbiter16_if.sv
// Request/grant bundle for the 16-way round-robin arbiter.
// The master drives requests and completion; the slave (arbiter) returns the grant.
interface rr_arbiter16_if;
  logic [15:0] REQ;
  logic        DONE;
  logic [15:0] GNT;
  logic [3:0]  GNT_ID;
  logic        GNT_VALID;
  logic        TIMEOUT;

  modport master (
    output REQ, DONE,
    input  GNT, GNT_ID, GNT_VALID, TIMEOUT
  );

  modport slave (
    input  REQ, DONE,
    output GNT, GNT_ID, GNT_VALID, TIMEOUT
  );
endinterface

// File: rtl/rr_arbiter16.sv
// 16-way round-robin arbiter: two-state FSM, registered outputs, hold-limit timeout.
// A grant always ends in at least one IDLE cycle before the next arbitration.
module rr_arbiter16 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic          CLK,
  input  logic          RST,
  rr_arbiter16_if.slave bus
);

  typedef enum logic {IDLE, GRANT} state_e;

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);
  // With the limit disabled the counter still needs a ceiling to avoid wrapping.
  localparam logic [7:0] CNT_SAT  = (MAX_HOLD == 0) ? 8'hFF : 8'(MAX_HOLD);

  state_e      state_q, state_d;
  logic [3:0]  ptr_q, ptr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] gnt_q, gnt_d;
  logic [3:0]  gnt_id_q, gnt_id_d;
  logic        gnt_valid_q, gnt_valid_d;
  logic        timeout_q, timeout_d;

  logic [3:0]  win_id;
  logic        win_vld;
  logic [3:0]  idx;
  logic        hold_hit;
  logic        req_kept;

  // First set request at or above ptr_q, wrapping 15 -> 0.
  always_comb begin
    win_id  = '0;
    win_vld = 1'b0;
    idx     = '0;
    for (int i = 0; i < 16; i++) begin
      idx = ptr_q + 4'(i);
      if (!win_vld && bus.REQ[idx]) begin
        win_id  = idx;
        win_vld = 1'b1;
      end
    end
  end

  assign hold_hit = (HOLD_LIM != 8'd0) && (cnt_q == HOLD_LIM);
  assign req_kept = bus.REQ[gnt_id_q];

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d     = GRANT;
          ptr_d       = win_id + 4'd1;
          cnt_d       = 8'd1;
          gnt_d       = 16'h0001 << win_id;
          gnt_id_d    = win_id;
          gnt_valid_d = 1'b1;
        end
      end
      GRANT: begin
        if (bus.DONE || !req_kept || hold_hit) begin
          state_d     = IDLE;
          cnt_d       = 8'd0;
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          // Only a pure hold-limit revocation is reported.
          timeout_d   = hold_hit && !bus.DONE && req_kept;
        end else if (cnt_q != CNT_SAT) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.GNT       = gnt_q;
  assign bus.GNT_ID    = gnt_id_q;
  assign bus.GNT_VALID = gnt_valid_q;
  assign bus.TIMEOUT   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter16.sv
// Directed bench for rr_arbiter16 (MAX_HOLD=8) with hand-derived grant sequences.
module tb_rr_arbiter16;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  rr_arbiter16_if bus ();

  rr_arbiter16 #(.MAX_HOLD(8)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected output state after an edge.
  task automatic exp_st(input string tag, input logic v, input logic [3:0] id, input logic to);
    logic [15:0] e;
    e = v ? (16'h0001 << id) : 16'h0000;
    chk({tag, ".vld"}, 32'(bus.GNT_VALID), 32'(v));
    chk({tag, ".gnt"}, 32'(bus.GNT), 32'(e));
    if (v) chk({tag, ".id"}, 32'(bus.GNT_ID), 32'(id));
    chk({tag, ".to"}, 32'(bus.TIMEOUT), 32'(to));
  endtask

  initial begin
    logic [3:0] seq [3];
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    bus.REQ  = 16'h0000;
    bus.DONE = 1'b0;

    // Reset state
    tick();
    exp_st("rst", 1'b0, 4'd0, 1'b0);
    chk("rst.id", 32'(bus.GNT_ID), 32'd0);

    // Two requesters held: 8-cycle grants, timeout pulse, single idle gap, wrap
    rst     = 1'b0;
    bus.REQ = 16'h8001;
    seq[0] = 4'd0; seq[1] = 4'd15; seq[2] = 4'd0;
    for (int g = 0; g < 3; g++) begin
      for (int c = 0; c < 8; c++) begin
        tick();
        exp_st("hold.g", 1'b1, seq[g], 1'b0);
      end
      tick();
      exp_st("hold.to", 1'b0, 4'd0, 1'b1);
    end
    bus.REQ  = 16'h0000;
    bus.DONE = 1'b1;
    tick();
    exp_st("idle.noreq", 1'b0, 4'd0, 1'b0);
    bus.DONE = 1'b0;

    // All requesting, DONE on the 2nd grant cycle: 0..15 then 0
    rst = 1'b1;
    tick();
    rst     = 1'b0;
    bus.REQ = 16'hFFFF;
    for (int k = 0; k < 17; k++) begin
      tick();
      exp_st("all.c1", 1'b1, 4'(k % 16), 1'b0);
      tick();
      exp_st("all.c2", 1'b1, 4'(k % 16), 1'b0);
      bus.DONE = 1'b1;
      tick();
      exp_st("all.gap", 1'b0, 4'd0, 1'b0);
      bus.DONE = 1'b0;
    end

    // Single requester 5 re-granted after one idle cycle each time (ptr=1 here)
    bus.REQ = 16'h0020;
    for (int k = 0; k < 3; k++) begin
      tick();
      exp_st("one.g", 1'b1, 4'd5, 1'b0);
      bus.DONE = 1'b1;
      tick();
      exp_st("one.gap", 1'b0, 4'd0, 1'b0);
      bus.DONE = 1'b0;
    end
    bus.REQ = 16'h0000;
    tick();
    exp_st("one.end", 1'b0, 4'd0, 1'b0);

    // ptr=6: grant 3 via wrap, drop REQ[3] and raise REQ[2]
    bus.REQ = 16'h0008;
    tick();
    exp_st("drop.g3", 1'b1, 4'd3, 1'b0);
    bus.REQ = 16'h0004;
    tick();
    exp_st("drop.exit", 1'b0, 4'd0, 1'b0);
    tick();
    exp_st("drop.g2", 1'b1, 4'd2, 1'b0);
    // Other bits rising mid-grant do not disturb the grantee
    bus.REQ = 16'h0007;
    tick();
    exp_st("mid.keep", 1'b1, 4'd2, 1'b0);
    bus.DONE = 1'b1;
    tick();
    exp_st("mid.gap", 1'b0, 4'd0, 1'b0);
    bus.DONE = 1'b0;
    tick();
    exp_st("mid.g0", 1'b1, 4'd0, 1'b0);
    bus.DONE = 1'b1;
    bus.REQ  = 16'h0000;
    tick();
    exp_st("mid.end", 1'b0, 4'd0, 1'b0);
    bus.DONE = 1'b0;

    // DONE together with the hold limit: no timeout
    bus.REQ = 16'h0010;
    for (int c = 0; c < 8; c++) begin
      tick();
      exp_st("dh.g", 1'b1, 4'd4, 1'b0);
    end
    bus.DONE = 1'b1;
    tick();
    exp_st("dh.exit", 1'b0, 4'd0, 1'b0);
    bus.DONE = 1'b0;
    bus.REQ  = 16'h0000;
    tick();

    // ptr=5: grant 5, reset mid-grant, then arbitration restarts from 0
    bus.REQ = 16'h0060;
    tick();
    exp_st("rm.g5", 1'b1, 4'd5, 1'b0);
    tick();
    exp_st("rm.g5b", 1'b1, 4'd5, 1'b0);
    rst = 1'b1;
    tick();
    exp_st("rm.rst", 1'b0, 4'd0, 1'b0);
    chk("rm.rst.id", 32'(bus.GNT_ID), 32'd0);
    rst = 1'b0;
    tick();
    exp_st("rm.g5again", 1'b1, 4'd5, 1'b0);
    bus.REQ = 16'h0000;
    tick();
    exp_st("rm.end", 1'b0, 4'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
